// File: rtl/data_demux_module_fsm.sv
// Splits the time-division-multiplexed word stream back into DS1/DS2/DS3 using the mux framing.
// Optional statistics counters are built only when DEMUX_STATS_EN is defined.
module data_demux_module_fsm #(
  parameter int DATA_W      = 32,
  parameter int MUX_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              symbol_clk,
  input  logic [2:0]        mode,
  input  logic [31:0]       switch_clk_cycles,
  input  logic [DATA_W-1:0] mux_data,
  output logic [DATA_W-1:0] ds1_out,
  output logic [DATA_W-1:0] ds2_out,
  output logic [DATA_W-1:0] ds3_out,
  output logic [2:0]        ds_valid,
  output logic [1:0]        slot_idx,
  output logic              frame_err,
  output logic [15:0]       symbol_count,
  output logic [7:0]        overrun_count
);

  typedef enum logic [1:0] {IDLE, ALIGN, SLOT, HOLD} state_t;

  localparam bit         NO_ALIGN   = (MUX_LATENCY == 0);
  localparam logic [2:0] ALIGN_LAST = (MUX_LATENCY > 0) ? 3'(MUX_LATENCY - 1) : 3'd0;

  state_t      state;
  logic        sym_d;
  logic [2:0]  shadow_mode;
  logic [31:0] shadow_cyc;
  logic [31:0] cyc;
  logic [1:0]  slot;
  logic [2:0]  align_cnt;

  logic sym_rise;
  logic overrun;
  logic mode_ok;
  logic cyc_last;
  logic slot_last;

  assign sym_rise  = symbol_clk & ~sym_d;
  assign overrun   = sym_rise && ((state == ALIGN) || (state == SLOT));
  assign mode_ok   = (mode != 3'd0) && (mode <= 3'd3);
  assign cyc_last  = (cyc == (shadow_cyc - 32'd1));
  assign slot_last = ({1'b0, slot} == (shadow_mode - 3'd1));

  // A new symbol edge always restarts the frame, even over a capture in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sym_d       <= 1'b0;
      shadow_mode <= 3'd0;
      shadow_cyc  <= 32'd1;
      cyc         <= 32'd0;
      slot        <= 2'd0;
      align_cnt   <= 3'd0;
      ds1_out     <= '0;
      ds2_out     <= '0;
      ds3_out     <= '0;
      ds_valid    <= 3'b000;
      slot_idx    <= 2'd3;
      frame_err   <= 1'b0;
    end else begin
      sym_d    <= symbol_clk;
      ds_valid <= 3'b000;
      if (sym_rise) begin
        shadow_mode <= mode;
        shadow_cyc  <= (switch_clk_cycles == 32'd0) ? 32'd1 : switch_clk_cycles;
        cyc         <= 32'd0;
        slot        <= 2'd0;
        align_cnt   <= 3'd0;
        if (overrun) begin
          frame_err <= 1'b1;
        end
        if (!mode_ok) begin
          frame_err <= 1'b1;
          state     <= HOLD;
          slot_idx  <= 2'd3;
        end else if (NO_ALIGN) begin
          state    <= SLOT;
          slot_idx <= 2'd0;
        end else begin
          state    <= ALIGN;
          slot_idx <= 2'd3;
        end
      end else begin
        case (state)
          ALIGN: begin
            if (align_cnt == ALIGN_LAST) begin
              state    <= SLOT;
              slot     <= 2'd0;
              cyc      <= 32'd0;
              slot_idx <= 2'd0;
            end else begin
              align_cnt <= align_cnt + 3'd1;
            end
          end
          SLOT: begin
            if (cyc_last) begin
              case (slot)
                2'd0: begin
                  ds1_out  <= mux_data;
                  ds_valid <= 3'b001;
                end
                2'd1: begin
                  ds2_out  <= mux_data;
                  ds_valid <= 3'b010;
                end
                2'd2: begin
                  ds3_out  <= mux_data;
                  ds_valid <= 3'b100;
                end
                default: ds_valid <= 3'b000;
              endcase
              cyc <= 32'd0;
              if (slot_last) begin
                state    <= HOLD;
                slot_idx <= 2'd3;
              end else begin
                slot     <= slot + 2'd1;
                slot_idx <= slot + 2'd1;
              end
            end else begin
              cyc <= cyc + 32'd1;
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

`ifdef DEMUX_STATS_EN
  // Both counters saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge clk) begin
    if (rst) begin
      symbol_count  <= 16'd0;
      overrun_count <= 8'd0;
    end else begin
      if (sym_rise && (symbol_count != 16'hFFFF)) begin
        symbol_count <= symbol_count + 16'd1;
      end
      if (overrun && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end
    end
  end
`else
  assign symbol_count  = 16'd0;
  assign overrun_count = 8'd0;
`endif

endmodule
